// File: rtl/if_fetch_bpred_if.sv
// Fetch-stage bus: hazard/EX control and resolved-branch updates in,
// fetch PC and prediction out. Used by if_fetch_bpred through the slave modport.
// Protocol: there is no backpressure. i_EX_update and i_EX_redirect are
// single-cycle valid strobes sampled at the rising clock edge, and their
// payloads are meaningful only while the strobe is high. The o_IF_* signals
// are valid every cycle outside reset.
interface if_fetch_bpred_if;
  logic        i_stall;
  logic        i_EX_redirect;
  logic [31:0] i_EX_redirect_pc;
  logic        i_EX_update;
  logic [31:0] i_EX_pc;
  logic        i_EX_taken;
  logic [31:0] i_EX_target;
  logic [31:0] o_IF_pc;
  logic [31:0] o_IF_pc_four;
  logic        o_IF_pred;

  modport slave (
    input  i_stall, i_EX_redirect, i_EX_redirect_pc,
    input  i_EX_update, i_EX_pc, i_EX_taken, i_EX_target,
    output o_IF_pc, o_IF_pc_four, o_IF_pred
  );

  modport master (
    output i_stall, i_EX_redirect, i_EX_redirect_pc,
    output i_EX_update, i_EX_pc, i_EX_taken, i_EX_target,
    input  o_IF_pc, o_IF_pc_four, o_IF_pred
  );
endinterface

// File: rtl/if_fetch_bpred.sv
// RV32I instruction-fetch stage: PC register, next-PC selection and an
// optional direct-mapped BTB with 2-bit saturating counters.
// Build option: define IF_BTB_PRED_EN to compile in the BTB predictor;
// without it the stage fetches sequentially (redirect / hold / pc+4).
module if_fetch_bpred #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  if_fetch_bpred_if.slave    bus
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_four;
  logic [31:0] w_next_pc;
  logic        w_pred;
  logic [31:0] w_pred_target;

  assign w_pc_four        = r_pc + 32'd4;
  assign bus.o_IF_pc      = r_pc;
  assign bus.o_IF_pc_four = w_pc_four;
  assign bus.o_IF_pred    = w_pred;

`ifdef IF_BTB_PRED_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic             r_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] r_tag    [BTB_ENTRIES];
  logic [31:0]      r_target [BTB_ENTRIES];
  logic [1:0]       r_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic             w_unused_pc_lsb;

  // Fetch lookup uses the pre-update table, so a same-cycle update is not seen.
  assign w_lk_idx      = r_pc[IDX_W+1:2];
  assign w_lk_tag      = r_pc[31:IDX_W+2];
  assign w_pred        = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag)
                         && r_ctr[w_lk_idx][1];
  assign w_pred_target = r_target[w_lk_idx];

  assign w_up_idx        = bus.i_EX_pc[IDX_W+1:2];
  assign w_up_tag        = bus.i_EX_pc[31:IDX_W+2];
  assign w_up_hit        = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_unused_pc_lsb = ^bus.i_EX_pc[1:0];

  // BTB training from EX; independent of stall and redirect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (bus.i_EX_update) begin
      if (w_up_hit) begin
        if (bus.i_EX_taken) begin
          r_ctr[w_up_idx]    <= (r_ctr[w_up_idx] == 2'b11) ? 2'b11 : r_ctr[w_up_idx] + 2'd1;
          r_target[w_up_idx] <= bus.i_EX_target;
        end else begin
          r_ctr[w_up_idx]    <= (r_ctr[w_up_idx] == 2'b00) ? 2'b00 : r_ctr[w_up_idx] - 2'd1;
        end
      end else if (bus.i_EX_taken) begin
        // Miss and taken: allocate, replacing whatever aliased entry was there.
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= bus.i_EX_target;
        r_ctr[w_up_idx]    <= 2'b10;
      end
    end
  end
`else
  logic w_unused_ex;

  assign w_pred        = 1'b0;
  assign w_pred_target = w_pc_four;
  assign w_unused_ex   = ^{bus.i_EX_update, bus.i_EX_pc, bus.i_EX_taken, bus.i_EX_target};
`endif

  // Next-PC select: redirect beats stall, stall beats prediction.
  always_comb begin
    w_next_pc = w_pc_four;
    if (bus.i_EX_redirect) begin
      w_next_pc = bus.i_EX_redirect_pc;
    end else if (bus.i_stall) begin
      w_next_pc = r_pc;
    end else if (w_pred) begin
      w_next_pc = w_pred_target;
    end
  end

  // PC register; misaligned values are passed through untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

endmodule

// File: doc/if_fetch_bpred.md
# if_fetch_bpred

Instruction-fetch stage for the RV32I five-stage pipeline. It holds the program counter, selects the next PC, and predicts branch direction and target using a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Its outputs feed the IF/ID pipeline register (pc, pc+4 and prediction bit), and it accepts resolved-branch updates and redirects from EX.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `BTB_ENTRIES`, default 64: number of BTB entries. Must be a power of two, 4..1024. `IDX_W` = log2(`BTB_ENTRIES`).
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_stall`  in  1  hold the PC. Driven by hazard unit; same signal as the IF/ID stall.
- `i_EX_redirect`  in  1  misprediction detected in EX; load `i_EX_redirect_pc`.
- `i_EX_redirect_pc`  in  32  correct next PC after a misprediction.
- `i_EX_update`  in  1  an EX-resolved branch/jump is valid this cycle.
- `i_EX_pc`  in  32  PC of the resolved branch.
- `i_EX_taken`  in  1  actual direction of the resolved branch.
- `i_EX_target`  in  32  actual taken target.
- `o_IF_pc`  out  32  current fetch PC; also the imem address.
- `o_IF_pc_four`  out  32  `o_IF_pc` + 4, modulo 2^32.
- `o_IF_pred`  out  1  predicted-taken bit for the instruction at `o_IF_pc`. Goes to IF/ID and is carried to EX for the misprediction check.

## Operation
- **Index and tag.** index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- **BTB entry contents.** valid (1), tag, target (32), ctr (2).
  - Reset: valid=0, ctr=2'b01 (weakly not-taken), tag/target=0.
- **Lookup.** Combinational on `o_IF_pc`. hit = valid && tag match. `o_IF_pred` = hit && ctr[1].
- **Next-PC priority, highest first:**
  1. `i_EX_redirect` → `i_EX_redirect_pc`. Applies even when `i_stall`=1.
  2. `i_stall` → hold the PC.
  3. `o_IF_pred` → BTB target.
  4. Otherwise → `o_IF_pc_four`.
- **Update.** When `i_EX_update`=1, at the clock edge, on the entry indexed by `i_EX_pc`:
  - Hit, taken: ctr = sat_inc(ctr), target = `i_EX_target`.
  - Hit, not-taken: ctr = sat_dec(ctr).
  - Miss, taken: allocate/replace. valid=1, tag, target, ctr=2'b10 (weakly taken).
  - Miss, not-taken: no change. No allocation.
  - Saturation: ctr stays at 2'b11 on increment and 2'b00 on decrement.
- Updates proceed regardless of `i_stall` and `i_EX_redirect`.
- The PC is never forced aligned; a misaligned redirect target is passed through unchanged.

## Timing
- PC register, BTB state and all outputs are reset asynchronously. Outputs after reset: `o_IF_pc`=`RESET_PC`, `o_IF_pc_four`=`RESET_PC`+4, `o_IF_pred`=0.
- `o_IF_pc` changes only at the rising edge. `o_IF_pc_four` and `o_IF_pred` are combinational from the PC register and BTB state.
- Prediction has zero-cycle latency: a predicted-taken branch fetched in cycle N gives fetch PC = target in cycle N+1.
- BTB writes take effect at the edge. A lookup in the same cycle as an update to the same index sees the pre-update state.
- Redirect costs one cycle: PC = `i_EX_redirect_pc` in the cycle after `i_EX_redirect`. Flushing IF/ID and ID/EX is handled outside this block.
- Reset asserted mid-operation: PC and table return to their reset state immediately, regardless of clock.

## Configuration
- `IF_BTB_PRED_EN` defined: BTB, counters and update logic are compiled in, as described above.
- `IF_BTB_PRED_EN` undefined:
  - No BTB storage is instantiated.
  - `o_IF_pred` is tied to 0 and next PC is redirect / hold / pc+4.
  - `i_EX_update`, `i_EX_pc`, `i_EX_taken` and `i_EX_target` are ignored.

## Test plan
- **Reset.** `RESET_PC`=32'h100, assert `i_rst_n`=0 mid-run → pc=0x100, pc_four=0x104, pred=0, then sequential fetch 0x104, 0x108 on following cycles.
- **Stall/redirect priority.** `i_stall`=1 for 3 cycles at pc=0x20 → pc holds 0x20. Assert redirect to 0x400 while stalled → pc=0x400 next cycle.
- **Training.**
  - Update pc=0x40, taken, target=0x80 → next visit to 0x40 gives pred=1 and next pc=0x80.
  - Two not-taken updates → ctr=00, pred=0, next pc=0x44.
- **Saturation.** Five taken updates on 0x40, then one not-taken → ctr=10, still predicts taken. A second not-taken → ctr=01, predicts not-taken.
- **Aliasing and same-cycle hazard.**
  - `BTB_ENTRIES`=64: train 0x40 taken, then taken update at 0x140 (same index, different tag) → 0x40 misses (pred=0), 0x140 hits with ctr=10.
  - Update and lookup of the same index in one cycle → old prediction used that cycle.
- **Build without `IF_BTB_PRED_EN`.** Repeated taken updates → pred stays 0, pc always advances by 4 unless redirected.
